// File: rtl/mem_loader.sv
// Program loader: fills a 16-bit block RAM from a big-endian byte stream
// (length, words, checksum), then reads it back and checks the sum.
module mem_loader #(
    parameter int bits = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wren_n,
    output logic        oen_n,
    output logic [15:0] wraddress,
    output logic [15:0] rdaddress,
    output logic [15:0] data_out,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err
);

    localparam logic [16:0] CAPACITY  = 17'(1) << bits;
    localparam logic [15:0] ADDR_MASK = 16'(CAPACITY - 17'd1);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO, VERIFY, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] rx_sum_q, rx_sum_d;
    logic [15:0] rb_sum_q, rb_sum_d;
    logic [2:0]  err_q, err_d;
    logic        wren_n_q, wren_n_d;
    logic        oen_n_q, oen_n_d;
    logic [15:0] wraddress_q, wraddress_d;
    logic [15:0] rdaddress_q, rdaddress_d;
    logic [15:0] data_out_q, data_out_d;
    logic        byte_ready_q, byte_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        accept;
    logic [15:0] word;

    assign accept = byte_valid & byte_ready_q;
    assign word   = {hi_q, byte_in};

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        rx_sum_d    = rx_sum_q;
        rb_sum_d    = rb_sum_q;
        err_d       = err_q;
        wren_n_d    = 1'b1;
        oen_n_d     = 1'b1;
        wraddress_d = wraddress_q;
        rdaddress_d = rdaddress_q;
        data_out_d  = data_out_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d    = 3'b000;
                    idx_d    = 16'd0;
                    rx_sum_d = 16'd0;
                    rb_sum_d = 16'd0;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI, DAT_HI, SUM_HI: begin
                if (accept) begin
                    hi_d    = byte_in;
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = word;
                    if ({1'b0, word} > CAPACITY) begin
                        err_d[2] = 1'b1;
                        state_d  = DONE;
                    end else if (word == 16'd0) begin
                        state_d = SUM_HI;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_LO: begin
                if (accept) begin
                    wren_n_d    = 1'b0;
                    data_out_d  = word;
                    wraddress_d = idx_q & ADDR_MASK;
                    rx_sum_d    = rx_sum_q + word;
                    idx_d       = idx_q + 16'd1;
                    state_d     = (idx_d == len_q) ? SUM_HI : DAT_HI;
                end
            end
            SUM_LO: begin
                if (accept) begin
                    csum_d   = word;
                    err_d[0] = (rx_sum_q != word);
                    idx_d    = 16'd0;
                    rb_sum_d = 16'd0;
                    state_d  = VERIFY;
                    if (len_q != 16'd0) begin
                        oen_n_d     = 1'b0;
                        rdaddress_d = 16'd0;
                    end
                end
            end
            VERIFY: begin
                // idx_q counts verify cycles; data for read i-1 arrives in cycle i.
                if (idx_q != 16'd0) rb_sum_d = rb_sum_q + rd_data;
                if (idx_q == len_q) begin
                    err_d[1] = (rb_sum_d != csum_q);
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 16'd1;
                    if (idx_d != len_q) begin
                        oen_n_d     = 1'b0;
                        rdaddress_d = idx_d & ADDR_MASK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        byte_ready_d = state_d inside {LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO};
        busy_d       = !(state_d inside {IDLE, DONE});
        done_d       = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            hi_q         <= '0;
            csum_q       <= '0;
            rx_sum_q     <= '0;
            rb_sum_q     <= '0;
            err_q        <= '0;
            wren_n_q     <= 1'b1;
            oen_n_q      <= 1'b1;
            wraddress_q  <= '0;
            rdaddress_q  <= '0;
            data_out_q   <= '0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            hi_q         <= hi_d;
            csum_q       <= csum_d;
            rx_sum_q     <= rx_sum_d;
            rb_sum_q     <= rb_sum_d;
            err_q        <= err_d;
            wren_n_q     <= wren_n_d;
            oen_n_q      <= oen_n_d;
            wraddress_q  <= wraddress_d;
            rdaddress_q  <= rdaddress_d;
            data_out_q   <= data_out_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign wren_n     = wren_n_q;
    assign oen_n      = oen_n_q;
    assign wraddress  = wraddress_q;
    assign rdaddress  = rdaddress_q;
    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed and random streams against a
// stream-level reference model, with a registered-read RAM model attached.
module tb_mem_loader;

    localparam int BITS = 13;
    localparam int CAP  = 1 << BITS;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready, wren_n, oen_n, busy, done;
    logic [15:0] wraddress, rdaddress, data_out;
    logic [15:0] rd_data = 16'h0000;
    logic [2:0]  err;

    mem_loader #(.bits(BITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .wren_n(wren_n),
        .oen_n(oen_n), .wraddress(wraddress), .rdaddress(rdaddress),
        .data_out(data_out), .rd_data(rd_data), .busy(busy), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM model with registered read data; optional corruption of address 1.
    logic [15:0] mem [0:CAP-1];
    bit corrupt = 1'b0;
    int cyc = 0;
    int wr_addr[$], wr_data[$], rd_addr[$], rd_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!wren_n) begin
            mem[wraddress[BITS-1:0]] <= data_out;
            wr_addr.push_back(int'(wraddress));
            wr_data.push_back(int'(data_out));
        end
        if (!oen_n) begin
            rd_data <= (corrupt && rdaddress == 16'd1) ? 16'hABCC : mem[rdaddress[BITS-1:0]];
            rd_addr.push_back(int'(rdaddress));
            rd_cyc.push_back(cyc);
        end
    end

    // Called and returns just after a falling edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
        byte_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (byte_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input string name, input bq_t s, input int max_gap,
                            input bit mid_start, input bit corrupt_rd);
        int n, nbytes;
        logic [15:0] words[$];
        logic [15:0] c, sum, rb;
        logic [2:0] exp_err;
        bit ok;

        // Reference model: parse stream and derive the expected result.
        n = int'({s[0], s[1]});
        words.delete();
        if (n > CAP) begin
            exp_err = 3'b100;
            n = 0;
            nbytes = 2;
        end else begin
            sum = 16'd0;
            rb  = 16'd0;
            for (int i = 0; i < n; i++) begin
                words.push_back({s[2+2*i], s[3+2*i]});
                sum += words[i];
                rb  += (corrupt_rd && i == 1) ? 16'hABCC : words[i];
            end
            c = {s[2+2*n], s[3+2*n]};
            exp_err = {1'b0, rb != c, sum != c};
            nbytes = 4 + 2*n;
        end

        corrupt = corrupt_rd;
        wr_addr.delete(); wr_data.delete(); rd_addr.delete(); rd_cyc.delete();

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_start_busy"}, busy, 1'b1);
        check({name, "_start_done_clr"}, done, 1'b0);
        check({name, "_start_err_clr"}, err, 3'b000);

        for (int i = 0; i < nbytes; i++) begin
            if (mid_start && i == 3) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(s[i], max_gap, ok);
            if (!ok) begin
                check({name, "_byte_accept"}, 1'b0, 1'b1);
                return;
            end
        end

        if (exp_err[2]) check({name, "_ovf_done_now"}, done, 1'b1);

        for (int t = 0; t < n + 20; t++) begin
            if (done) break;
            @(negedge clk);
        end
        check({name, "_done"}, done, 1'b1);
        check({name, "_busy_low"}, busy, 1'b0);
        check({name, "_err"}, err, exp_err);

        byte_valid = 1'b1;
        byte_in = 8'h5A;
        repeat (2) @(negedge clk);
        check({name, "_ready_low"}, byte_ready, 1'b0);
        byte_valid = 1'b0;

        check({name, "_wr_count"}, wr_addr.size(), n);
        check({name, "_rd_count"}, rd_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check($sformatf("%s_wr_addr%0d", name, i), wr_addr[i], i & (CAP - 1));
            check($sformatf("%s_wr_data%0d", name, i), wr_data[i], words[i]);
        end
        for (int i = 0; i < n && i < rd_addr.size(); i++) begin
            check($sformatf("%s_rd_addr%0d", name, i), rd_addr[i], i & (CAP - 1));
            check($sformatf("%s_rd_cyc%0d", name, i), rd_cyc[i] - rd_cyc[0], i);
        end
        corrupt = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_wren_n"}, wren_n, 1'b1);
        check({pfx, "_oen_n"}, oen_n, 1'b1);
        check({pfx, "_wraddress"}, wraddress, 16'h0000);
        check({pfx, "_rdaddress"}, rdaddress, 16'h0000);
        check({pfx, "_data_out"}, data_out, 16'h0000);
        check({pfx, "_byte_ready"}, byte_ready, 1'b0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_done"}, done, 1'b0);
        check({pfx, "_err"}, err, 3'b000);
    endtask

    initial begin
        bq_t s;
        bit ok;
        int n;
        logic [15:0] w, sum;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        run_load("normal", s, 0, 1'b0, 1'b0);

        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h00};
        run_load("badsum", s, 0, 1'b0, 1'b0);

        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        run_load("restart", s, 0, 1'b0, 1'b0);

        s = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_load("empty", s, 0, 1'b0, 1'b0);

        s = '{8'h20, 8'h01};
        run_load("ovf", s, 0, 1'b0, 1'b0);

        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        run_load("corrupt", s, 0, 1'b0, 1'b1);

        run_load("gaps", s, 5, 1'b1, 1'b0);

        // Abort during DAT_LO of word 1.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22};
        for (int i = 0; i < s.size(); i++) send_byte(s[i], 0, ok);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        run_load("after_rst", s, 0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(12, 0);
            s = '{8'(n >> 8), 8'(n)};
            sum = 16'd0;
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                sum += w;
                s.push_back(w[15:8]);
                s.push_back(w[7:0]);
            end
            if ($urandom_range(3, 0) == 0) sum ^= 16'(1 << $urandom_range(15, 0));
            s.push_back(sum[15:8]);
            s.push_back(sum[7:0]);
            run_load($sformatf("rand%0d", r), s, 3, r[0], (n >= 2) && (r == 5));
        end

        s = '{8'hFF, 8'hFF};
        run_load("ovf_max", s, 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program loader that fills the 16-bit block RAM from a byte stream and then reads it back for verification. It is the initiator/writer side of the RAM's port set: it drives the active-low write and output enables, both addresses, and the write data. It consumes the RAM's registered read data. It sits between the host byte link (UART receiver or bench) and the RAM, and holds the CPU off the RAM while a load is in progress.

## Interface
- `bits`, default 13: RAM address bits; capacity is 2^bits words.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: one-cycle pulse that begins a load. Ignored while `busy`.
- `byte_in`, input, 8: stream byte.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: loader accepts a byte. Transfer occurs on an edge where `byte_valid & byte_ready`.
- `wren_n`, output, 1: RAM write enable, active low.
- `oen_n`, output, 1: RAM read enable, active low.
- `wraddress`, output, 16: RAM write address; bits above `bits` are 0.
- `rdaddress`, output, 16: RAM read address; bits above `bits` are 0.
- `data_out`, output, 16: write data to the RAM.
- `rd_data`, input, 16: RAM registered read data.
- `busy`, output, 1: load in progress. Also serves as the CPU hold.
- `done`, output, 1: load finished. Held until the next accepted `start`.
- `err`, output, 3: error flags. Bit 0 = stream checksum mismatch; bit 1 = readback mismatch; bit 2 = length overflow.

## Operation
- Stream format, big-endian:
  - N_hi, N_lo: word count N.
  - N words, each sent high byte then low byte.
  - C_hi, C_lo: checksum C.
  - C is the 16-bit modular sum of all N words.
- States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI, SUM_LO, VERIFY, DONE.
- IDLE or DONE + `start`:
  - Clear `err`, `done`, the word index, and both sums.
  - Set `busy`; go to LEN_HI.
- `byte_ready` = 1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO, SUM_HI and SUM_LO. Each accepted byte advances exactly one state.
- LEN_LO accepted:
  - If N > 2^bits: set `err[2]` and go to DONE. No writes, no verify, no further bytes consumed.
  - If N = 0: go to SUM_HI.
  - Otherwise: go to DAT_HI.
- DAT_LO accepted:
  - Register one write: `data_out` = {hi, lo}, `wraddress` = index.
  - Add the word into rx_sum and increment the index.
  - Go to SUM_HI if index == N, else DAT_HI.
- SUM_LO accepted:
  - Set `err[0]` if rx_sum != C.
  - Reset the index and rb_sum; go to VERIFY.
- VERIFY:
  - Issue reads for addresses 0..N-1 on consecutive cycles.
  - Accumulate `rd_data` into rb_sum one cycle after each issue.
  - After the last accumulate, set `err[1]` if rb_sum != C, then go to DONE.
- DONE: `busy` = 0, `done` = 1, `err` held.
- All sums wrap mod 2^16. Addresses are truncated to `bits`.

## Timing
- Reset values: state IDLE; `wren_n` = 1, `oen_n` = 1, `wraddress` = 0, `rdaddress` = 0, `data_out` = 0, `byte_ready` = 0, `busy` = 0, `done` = 0, `err` = 000.
- Reset mid-load aborts immediately to IDLE. Partially written RAM contents are left as-is.
- All outputs are registered.
- Write timing:
  - `wren_n` goes low for exactly one cycle, in the cycle after the DAT_LO acceptance edge.
  - `wraddress` and `data_out` are stable in that cycle.
  - Writes never overlap, since the next word needs at least two more edges.
- `byte_valid` gaps of any length are tolerated. The state holds while `byte_valid` = 0.
- VERIFY read pipeline:
  - In cycle k: `oen_n` = 0 and `rdaddress` = i.
  - The RAM registers its output at the end of cycle k.
  - The loader samples `rd_data` at the end of cycle k+1.
- VERIFY lasts N+1 cycles. `oen_n` is low for exactly N cycles, back-to-back; with N = 0 it is never asserted.
- The last RAM write precedes VERIFY by at least two cycles, so there is no read-after-write hazard.
- `done` rises on the edge that enters DONE. `busy` falls on the same edge.
- A `start` arriving in DONE clears `done` on its acceptance edge.

## Test plan
- **Normal load.** Start, then bytes 00 02 12 34 AB CD BE 01.
  - Exactly two write strobes: addr 0 = 0x1234, addr 1 = 0xABCD.
  - Then two reads, at addresses 0 and 1.
  - `done` = 1, `err` = 000.
- **Bad trailer.** Same stream with trailer BE 00.
  - Both words are still written.
  - `err` = 011: rx_sum and rb_sum both differ from C.
- **Empty and overflow.**
  - Bytes 00 00 00 00: no `wren_n` or `oen_n` pulse; `done` with `err` = 000.
  - Bytes 20 01 (N = 0x2001 > 0x2000): `err` = 100 and `done` two edges later; `byte_ready` stays 0.
- **Readback corruption.** RAM model forces address 1 to read 0xABCC, with a correct stream.
  - `err` = 010.
- **Backpressure and restart.**
  - Normal load with random 0-5 cycle `byte_valid` gaps: identical write sequence and result.
  - `start` pulsed mid-load: ignored.
  - `start` in DONE: new load, `err` cleared.
- **Reset mid-op.** Assert `rst_n` = 0 during DAT_LO of word 1.
  - All outputs take their reset values.
  - A subsequent normal load completes with `err` = 000.
